// File: rtl/uart_time_reporter_pkg.sv
// Shared types and constants for the UART time reporter: FSM encoding,
// ASCII framing characters, frame lengths and a digit-to-ASCII helper.
package uart_time_reporter_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_FREE = 3'd1,
        S_STROBE    = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int FRAME_LEN_CRLF    = 13;
    localparam int FRAME_LEN_NO_CRLF = 11;
    localparam int IDX_W             = 4;

    // Decimal digit 0..9 to its ASCII character.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO | {4'h0, digit};
    endfunction

endpackage

// File: rtl/uart_time_reporter_if.sv
// Byte-level handshake between the time reporter and a UART transmitter.
interface uart_time_reporter_if;
    logic       start_trigger;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output start_trigger, output tx_data, input tx_busy);
    modport slave  (input start_trigger, input tx_data, output tx_busy);
endinterface

// File: rtl/uart_time_reporter_bin2dec2.sv
// Binary (0..127) to two decimal digits, saturating at 99.
module bin2dec2
    import uart_time_reporter_pkg::*;
(
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [6:0] sat;

    // Saturate, find the tens digit by threshold compare, derive units by subtraction.
    always_comb begin
        sat  = (bin > 7'd99) ? 7'd99 : bin;
        tens = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (sat >= 7'(k * 10)) tens = 4'(k);
        end
        // The true remainder is below 10, so 4-bit wraparound arithmetic is exact.
        units = sat[3:0] - tens * 4'd10;
    end

endmodule

// File: rtl/uart_time_reporter.sv
// Sends a snapshot of hour/min/sec/centisecond as "HH:MM:SS.CC" (optionally
// followed by CR LF) to a byte-wide UART transmitter, one strobe per byte.
module uart_time_reporter
    import uart_time_reporter_pkg::*;
#(
    parameter bit CRLF_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        send_req,
    input  logic [4:0]                  hour,
    input  logic [5:0]                  min,
    input  logic [5:0]                  sec,
    input  logic [6:0]                  msec,
    uart_time_reporter_if.master        tx,
    output logic                        busy,
    output logic                        done
);

    localparam logic [IDX_W-1:0] LAST_IDX = CRLF_EN ? IDX_W'(FRAME_LEN_CRLF - 1)
                                                    : IDX_W'(FRAME_LEN_NO_CRLF - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;

    logic [4:0] hour_snap;
    logic [5:0] min_snap;
    logic [5:0] sec_snap;
    logic [6:0] msec_snap;

    logic [3:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u, msec_t, msec_u;
    logic [7:0] byte_sel;

    bin2dec2 u_hour (.bin({2'b00, hour_snap}), .tens(hour_t), .units(hour_u));
    bin2dec2 u_min  (.bin({1'b0, min_snap}),   .tens(min_t),  .units(min_u));
    bin2dec2 u_sec  (.bin({1'b0, sec_snap}),   .tens(sec_t),  .units(sec_u));
    bin2dec2 u_msec (.bin(msec_snap),          .tens(msec_t), .units(msec_u));

    // State and byte index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state and byte index sequencing.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            S_IDLE: begin
                if (send_req) state_next = S_WAIT_FREE;
            end
            S_WAIT_FREE: begin
                if (!tx.tx_busy) state_next = S_STROBE;
            end
            S_STROBE: begin
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx.tx_busy) state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx.tx_busy) begin
                    if (idx == LAST_IDX) begin
                        state_next = S_FINISH;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = S_STROBE;
                    end
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Field snapshot taken when a request is accepted; frozen for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_snap <= '0;
            min_snap  <= '0;
            sec_snap  <= '0;
            msec_snap <= '0;
        end else if (state == S_IDLE && send_req) begin
            hour_snap <= hour;
            min_snap  <= min;
            sec_snap  <= sec;
            msec_snap <= msec;
        end
    end

    // Byte selection for the index that will be current in the next cycle.
    always_comb begin
        byte_sel = 8'h00;
        case (idx_next)
            4'd0:    byte_sel = digit_to_ascii(hour_t);
            4'd1:    byte_sel = digit_to_ascii(hour_u);
            4'd2:    byte_sel = ASCII_COLON;
            4'd3:    byte_sel = digit_to_ascii(min_t);
            4'd4:    byte_sel = digit_to_ascii(min_u);
            4'd5:    byte_sel = ASCII_COLON;
            4'd6:    byte_sel = digit_to_ascii(sec_t);
            4'd7:    byte_sel = digit_to_ascii(sec_u);
            4'd8:    byte_sel = ASCII_DOT;
            4'd9:    byte_sel = digit_to_ascii(msec_t);
            4'd10:   byte_sel = digit_to_ascii(msec_u);
            4'd11:   byte_sel = ASCII_CR;
            4'd12:   byte_sel = ASCII_LF;
            default: byte_sel = 8'h00;
        endcase
    end

    // Registered outputs, decoded from the state being entered so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx.start_trigger <= 1'b0;
            tx.tx_data       <= 8'h00;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            tx.start_trigger <= (state_next == S_STROBE);
            if (state_next == S_STROBE) tx.tx_data <= byte_sel;
            busy             <= (state_next != S_IDLE) && (state_next != S_FINISH);
            done             <= (state_next == S_FINISH);
        end
    end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Directed bench: two reporters (with and without CR LF) each driving a
// simple transmitter model that is busy for a few cycles per byte.
module tb_uart_time_reporter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_a = 1'b0;
    logic       send_b = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = '0;
    logic [6:0] msec = '0;
    logic       busy_a, done_a, busy_b, done_b;
    logic       force_a = 1'b0;

    int cnt_a = 0;
    int cnt_b = 0;

    uart_time_reporter_if if_a ();
    uart_time_reporter_if if_b ();

    assign if_a.tx_busy = (cnt_a != 0) || force_a;
    assign if_b.tx_busy = (cnt_b != 0);

    uart_time_reporter #(.CRLF_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .send_req(send_a),
        .hour(hour), .min(min), .sec(sec), .msec(msec),
        .tx(if_a.master), .busy(busy_a), .done(done_a)
    );

    uart_time_reporter #(.CRLF_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .send_req(send_b),
        .hour(hour), .min(min), .sec(sec), .msec(msec),
        .tx(if_b.master), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Transmitter models: busy from the cycle after a strobe, for four cycles.
    always @(posedge clk) begin
        if (if_a.start_trigger) cnt_a <= 4;
        else if (cnt_a != 0)    cnt_a <= cnt_a - 1;
        if (if_b.start_trigger) cnt_b <= 4;
        else if (cnt_b != 0)    cnt_b <= cnt_b - 1;
    end

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int viol_a = 0;
    int viol_b = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    // Byte capture, done counting and strobe protocol watch.
    always @(negedge clk) begin
        if (if_a.start_trigger) begin
            q_a.push_back(if_a.tx_data);
            if (if_a.tx_busy || prev_a) viol_a++;
        end
        if (if_b.start_trigger) begin
            q_b.push_back(if_b.tx_data);
            if (if_b.tx_busy || prev_b) viol_b++;
        end
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        prev_a = if_a.start_trigger;
        prev_b = if_b.start_trigger;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag, input bit use_b, input int base,
                               input logic [7:0] exp[$]);
        int n;
        logic [7:0] g;
        n = (use_b ? q_b.size() : q_a.size()) - base;
        check({tag, "_len"}, n, exp.size());
        foreach (exp[i]) begin
            if (i < n) g = use_b ? q_b[base + i] : q_a[base + i];
            else       g = 'x;
            check($sformatf("%s_byte%0d", tag, i), {24'h0, g}, {24'h0, exp[i]});
        end
    endtask

    task automatic pulse_send(input bit use_b);
        @(negedge clk);
        if (use_b) send_b = 1'b1;
        else       send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        send_b = 1'b0;
    endtask

    // Returns at the negedge inside the done (FINISH) cycle.
    task automatic wait_done(input bit use_b, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if ((use_b ? done_b : done_a) === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_bytes(input int base, input int n, input string tag);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk);
            if (q_a.size() - base >= n) reached = 1'b1;
        end
        check({tag, "_bytes_reached"}, 32'(reached), 32'd1);
    endtask

    initial begin
        logic [7:0] exp[$];
        int base;
        int dbase;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobe_a", 32'(if_a.start_trigger), 32'd0);
        check("rst_txdata_a", 32'(if_a.tx_data), 32'h00);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;

        // Scenario 1: 12:34:56.78 with CR LF
        hour = 5'd12; min = 6'd34; sec = 6'd56; msec = 7'd78;
        base = q_a.size(); dbase = done_cnt_a;
        pulse_send(1'b0);
        check("s1_busy_rise", 32'(busy_a), 32'd1);
        wait_done(1'b0, "s1");
        repeat (5) @(negedge clk);
        exp = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36,
                8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
        check_frame("s1", 1'b0, base, exp);
        check("s1_done_cnt", done_cnt_a - dbase, 32'd1);
        check("s1_busy_end", 32'(busy_a), 32'd0);
        check("s1_txdata_hold", 32'(if_a.tx_data), 32'h0A);

        // Scenario 2: all zero, no CR LF
        hour = '0; min = '0; sec = '0; msec = '0;
        base = q_b.size(); dbase = done_cnt_b;
        pulse_send(1'b1);
        wait_done(1'b1, "s2");
        repeat (5) @(negedge clk);
        exp = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30,
                8'h2E, 8'h30, 8'h30};
        check_frame("s2", 1'b1, base, exp);
        check("s2_done_cnt", done_cnt_b - dbase, 32'd1);
        check("s2_busy_end", 32'(busy_b), 32'd0);

        // Scenario 3: saturation and mid-frame field changes
        hour = 5'd31; min = 6'd5; sec = 6'd59; msec = 7'd127;
        base = q_a.size(); dbase = done_cnt_a;
        pulse_send(1'b0);
        repeat (20) @(negedge clk);
        hour = 5'd7; min = 6'd0; sec = 6'd0; msec = 7'd0;
        wait_done(1'b0, "s3");
        repeat (5) @(negedge clk);
        exp = '{8'h33, 8'h31, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h35, 8'h39,
                8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
        check_frame("s3", 1'b0, base, exp);

        // Scenario 4: transmitter busy for 50 cycles at request time
        hour = 5'd1; min = 6'd2; sec = 6'd3; msec = 7'd4;
        force_a = 1'b1;
        base = q_a.size(); dbase = done_cnt_a;
        pulse_send(1'b0);
        repeat (50) @(negedge clk);
        check("s4_no_strobe", q_a.size() - base, 32'd0);
        check("s4_busy_hold", 32'(busy_a), 32'd1);
        force_a = 1'b0;
        wait_done(1'b0, "s4");
        repeat (5) @(negedge clk);
        exp = '{8'h30, 8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33,
                8'h2E, 8'h30, 8'h34, 8'h0D, 8'h0A};
        check_frame("s4", 1'b0, base, exp);
        check("s4_done_cnt", done_cnt_a - dbase, 32'd1);

        // Scenario 5: requests at byte 5 and in the FINISH cycle are ignored
        hour = 5'd23; min = 6'd59; sec = 6'd59; msec = 7'd100;
        base = q_a.size(); dbase = done_cnt_a;
        pulse_send(1'b0);
        wait_bytes(base, 5, "s5");
        pulse_send(1'b0);
        wait_done(1'b0, "s5");
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        check("s5_busy_after_finish_req", 32'(busy_a), 32'd0);
        repeat (100) @(negedge clk);
        exp = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39,
                8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
        check_frame("s5", 1'b0, base, exp);
        check("s5_done_cnt", done_cnt_a - dbase, 32'd1);
        check("s5_busy_idle", 32'(busy_a), 32'd0);

        // Scenario 6: asynchronous reset mid-frame, then a clean frame
        hour = 5'd12; min = 6'd34; sec = 6'd56; msec = 7'd78;
        base = q_a.size();
        pulse_send(1'b0);
        wait_bytes(base, 7, "s6");
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("s6_rst_strobe", 32'(if_a.start_trigger), 32'd0);
        check("s6_rst_txdata", 32'(if_a.tx_data), 32'h00);
        check("s6_rst_busy", 32'(busy_a), 32'd0);
        check("s6_rst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("s6_idle_after_rst", 32'(busy_a), 32'd0);
        base = q_a.size(); dbase = done_cnt_a;
        pulse_send(1'b0);
        wait_done(1'b0, "s6");
        repeat (5) @(negedge clk);
        exp = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36,
                8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
        check_frame("s6", 1'b0, base, exp);
        check("s6_done_cnt", done_cnt_a - dbase, 32'd1);

        // Strobe protocol over the whole run
        check("proto_a", viol_a, 32'd0);
        check("proto_b", viol_b, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_time_reporter.md
UART_TIME_REPORTER -- requirements
Module: uart_time_reporter

Interface
REQ-001 Parameter: CRLF_EN, default 1, appends CR (0x0D) and LF (0x0A) to each frame when 1; omits them when 0.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: send_req  input  1  single-cycle request to transmit one time frame.
REQ-005 Port: hour  input  5  hours, binary.
REQ-006 Port: min  input  6  minutes, binary.
REQ-007 Port: sec  input  6  seconds, binary.
REQ-008 Port: msec  input  7  centiseconds, binary.
REQ-009 Port: tx_busy  input  1  busy flag from the UART transmitter.
REQ-010 Port: start_trigger  output  1  one-cycle byte-start strobe to the UART transmitter.
REQ-011 Port: tx_data  output  8  byte presented to the UART transmitter; valid while start_trigger=1.
REQ-012 Port: busy  output  1  high from request acceptance until the frame completes.
REQ-013 Port: done  output  1  one-cycle pulse when the last byte of a frame has finished.

Function
REQ-014 Frame format: ASCII "HH:MM:SS.CC" plus "\r\n" when CRLF_EN=1; 13 bytes with CRLF, 11 without.
REQ-015 Each field is two decimal ASCII digits: tens = value/10, units = value%10, plus 0x30.
REQ-016 Any field value above 99 saturates to "99".
REQ-017 When send_req=1 in IDLE, all four fields are snapshotted in the same cycle, and busy rises the next cycle.
REQ-018 A send_req arriving while busy=1 is ignored; requests are not queued.
REQ-019 The state machine has states IDLE, WAIT_FREE, STROBE, WAIT_ACK, WAIT_DONE and FINISH.
REQ-020 WAIT_FREE: stay while tx_busy=1; when tx_busy=0, go to STROBE.
REQ-021 STROBE: start_trigger=1 and tx_data=current byte for exactly one cycle, then go to WAIT_ACK.
REQ-022 WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. The transmitter raises tx_busy one cycle after the strobe.
REQ-023 WAIT_DONE: wait for tx_busy=0. If more bytes remain, increment the byte index and go to STROBE; otherwise go to FINISH.
REQ-024 FINISH: done=1 and busy=0 for one cycle, then go to IDLE. A send_req in the FINISH cycle is ignored.
REQ-025 start_trigger is never asserted while tx_busy=1, and is never asserted in two consecutive cycles.
REQ-026 tx_data holds its last value outside STROBE and is 0x00 after reset.
REQ-027 The byte index wraps to 0 on entry to IDLE; it never exceeds the frame length minus 1.
REQ-028 Changes on the field inputs during a frame have no effect on the frame being sent.

Reset
REQ-029 While rst=1: state=IDLE, start_trigger=0, tx_data=0x00, busy=0, done=0, byte index=0, snapshot=0.
REQ-030 Reset mid-frame aborts the frame immediately; there is no resume after rst deasserts.
REQ-031 The first send_req after reset deassertion is accepted normally.

Structure
REQ-032 A shared package holds the state encoding, the ASCII constants (0x30, 0x3A, 0x2E, 0x0D, 0x0A) and the frame lengths 11 and 13.
REQ-033 Binary-to-two-digit conversion is one sub-module, bin2dec2 (7-bit in, saturating, tens/units out), instantiated four times.
REQ-034 The byte multiplexer selected by byte index is combinational; all outputs are registered.

Verification
REQ-035 Scenario 1: hour=12, min=34, sec=56, msec=78, CRLF_EN=1, send_req -> bytes 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x2E 0x37 0x38 0x0D 0x0A, then exactly 1 done pulse.
REQ-036 Scenario 2: CRLF_EN=0, all fields 0, send_req -> "00:00:00.00" (11 bytes), done pulses, busy low.
REQ-037 Scenario 3: msec=127, hour=31 -> CC="99", HH="31"; fields changed mid-frame -> no change in transmitted bytes.
REQ-038 Scenario 4: tx_busy forced high for 50 cycles at request time -> no start_trigger until tx_busy=0; then normal frame.
REQ-039 Scenario 5: second send_req at byte 5 and another in the FINISH cycle -> both ignored; exactly one frame sent.
REQ-040 Scenario 6: rst pulse during byte 7 -> all outputs at reset values asynchronously; the next send_req sends a full, correct frame.
